// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word data memory for the MEM stage.
// Valid/ready request in, fixed-latency valid/ready response out.
module dmem_responder #(
  parameter int DMEM_DEPTH      = 1024,
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int LATENCY         = 2
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [DMEM_ADDR_WIDTH-1:0] idx;
  logic                       err;
  logic                       fire;

  logic [31:0] mem [DMEM_DEPTH];

  assign idx  = addr_q[DMEM_ADDR_WIDTH+1:2];
  assign err  = (addr_q[1:0] != 2'b00)
             || ((addr_q >> (DMEM_ADDR_WIDTH + 2)) != 32'd0);
  assign fire = (state == BUSY) && (cnt == 4'd0);

  assign req_ready  = (state == IDLE);
  assign busy       = ~req_ready;
  assign resp_valid = (state == RESP);

  // Request capture, latency countdown and response registers
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= CNT_INIT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state    <= RESP;
            resp_err <= err;
            if (err || wr_q) begin
              resp_rdata <= 32'd0;
            end else begin
              resp_rdata <= mem[idx];
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store commit on the final latency edge; reset on that edge cancels it
  always_ff @(posedge clk) begin
    if (reset_b && fire && wr_q && !err) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule
